// File: rtl/milano_pkg.sv
// rtl/milano_pkg.sv - shared types and constants for the milano fetch path
package milano_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush priority over push/pop
module fetch_fifo
    import milano_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_ni,
    input  logic          flush,
    input  logic          s_tvalid,
    input  entry_t        s_tdata,
    input  logic          m_tready,
    output entry_t        m_tdata,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign pop     = !empty && m_tready;
    assign m_tdata = mem[rd_ptr];
    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));

    // Storage is cleared on reset so the head reads as zero before the first push.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (s_tvalid) begin
                mem[wr_ptr] <= s_tdata;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            cnt <= cnt + CW'(s_tvalid) - CW'(pop);
        end
    end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC generation, imem bus, prefetch buffering, redirects
module if_stage
    import milano_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR  = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        id_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_rdata_o,
    output logic [31:0] instr_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = CW + 1;
    localparam int QW = $clog2(FIFO_DEPTH);
    localparam logic [OW-1:0] DEPTH_W = OW'(FIFO_DEPTH);

    if_state_e     state_q;
    logic [31:0]   pc_q;
    logic [31:0]   redirect_q;
    logic          redirect_pending_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] discard_q;
    logic [31:0]   pcq [FIFO_DEPTH];
    logic [QW-1:0] pcq_wr_q;
    logic [QW-1:0] pcq_rd_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          fifo_full;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;

    logic          pop;
    logic          fire;
    logic          drop;
    logic          push;
    logic          credit_ok;
    logic          stall_redirect;
    logic [CW-1:0] out_next;
    logic [CW-1:0] fifo_next;
    logic [OW-1:0] occ_now;
    logic [OW-1:0] occ_next;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(FIFO_DEPTH - 1)) ? '0 : p + QW'(1);
    endfunction

    // HOLD means the buffer and bus are full unless the consumer frees a slot
    // this very cycle; that pop still lets a request out so zero-wait memory
    // sustains one instruction per cycle.
    always_comb begin
        pop       = !fifo_empty && id_ready_i;
        occ_now   = branch_i ? {1'b0, outstanding_q}
                             : {1'b0, fifo_count} + {1'b0, outstanding_q} - OW'(pop);
        credit_ok = (occ_now < DEPTH_W);

        instr_req_o = (state_q == FETCH) || ((state_q == HOLD) && credit_ok);
        fire        = instr_req_o && instr_gnt_i;
        drop        = instr_rvalid_i && (discard_q != '0);
        push        = instr_rvalid_i && (discard_q == '0) && (!fifo_full || pop);

        out_next  = outstanding_q + CW'(fire) - CW'(instr_rvalid_i);
        fifo_next = branch_i ? '0 : fifo_count + CW'(push) - CW'(pop);
        occ_next  = {1'b0, fifo_next} + {1'b0, out_next};

        stall_redirect = branch_i && instr_req_o && !instr_gnt_i;

        push_entry.pc    = pcq[pcq_rd_q];
        push_entry.instr = instr_rdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q            <= BOOT;
            pc_q               <= word_align(BOOT_ADDR);
            redirect_q         <= '0;
            redirect_pending_q <= 1'b0;
            outstanding_q      <= '0;
            discard_q          <= '0;
            pcq_wr_q           <= '0;
            pcq_rd_q           <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pcq[i] <= '0;
            end
        end else begin
            if (state_q == BOOT || (instr_req_o && !instr_gnt_i) || occ_next < DEPTH_W) begin
                state_q <= FETCH;
            end else begin
                state_q <= HOLD;
            end

            outstanding_q <= out_next;
            if (fire) begin
                pcq[pcq_wr_q] <= pc_q;
                pcq_wr_q      <= q_next(pcq_wr_q);
            end
            if (instr_rvalid_i) begin
                pcq_rd_q <= q_next(pcq_rd_q);
            end

            // Everything still in flight after a redirect belongs to the old path.
            if (branch_i) begin
                discard_q <= out_next;
            end else begin
                discard_q <= discard_q - CW'(drop) + CW'(redirect_pending_q && fire);
            end

            if (stall_redirect) begin
                redirect_q         <= word_align(branch_target_i);
                redirect_pending_q <= 1'b1;
            end else if (branch_i) begin
                pc_q               <= word_align(branch_target_i);
                redirect_pending_q <= 1'b0;
            end else if (fire) begin
                pc_q               <= redirect_pending_q ? redirect_q : pc_q + 32'd4;
                redirect_pending_q <= 1'b0;
            end
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fetch_fifo (
        .clk      (clk_i),
        .rst_ni   (rst_ni),
        .flush    (branch_i),
        .s_tvalid (push),
        .s_tdata  (push_entry),
        .m_tready (id_ready_i),
        .m_tdata  (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    assign instr_addr_o  = pc_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_rdata_o = head.instr;
    assign instr_pc_o    = head.pc;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage against an address-stream model
module tb_if_stage;

    localparam logic [31:0] BOOT = 32'h0000_0080;
    localparam int          D    = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i = 1'b0;
    logic        instr_rvalid_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        id_ready_i = 1'b0;
    logic        instr_valid_o;
    logic [31:0] instr_rdata_o;
    logic [31:0] instr_pc_o;

    if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(D)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .id_ready_i      (id_ready_i),
        .instr_valid_o   (instr_valid_o),
        .instr_rdata_o   (instr_rdata_o),
        .instr_pc_o      (instr_pc_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    int          gnt_pct = 100;
    int          ready_pct = 100;
    int          lat_min = 1;
    int          lat_max = 1;

    // Model: the address the next request must carry and the PC the next consumed instruction must have.
    logic [31:0] mdl_fetch;
    logic [31:0] mdl_pend_tgt;
    logic        mdl_pend;
    logic [31:0] exp_pc;
    logic        prev_req;
    logic        prev_gnt;
    logic        prev_br;

    logic [31:0]  mq_addr[$];
    int unsigned  mq_due[$];
    int unsigned  last_due;
    logic [31:0]  glog[$];
    int           grants = 0;
    int           accepts = 0;
    logic         capture_first;
    logic [31:0]  first_acc_pc;
    logic         s_req;
    logic         s_valid;
    logic [31:0]  s_addr;
    logic [31:0]  s_pc;
    int           base;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16] ^ ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ni = 1'b0;
        instr_gnt_i = 1'b0;
        instr_rvalid_i = 1'b0;
        branch_i = 1'b0;
        id_ready_i = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        last_due = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", instr_req_o, 32'd0);
        chk("rst_addr", instr_addr_o, BOOT);
        chk("rst_valid", instr_valid_o, 32'd0);
        chk("rst_rdata", instr_rdata_o, 32'd0);
        chk("rst_pc", instr_pc_o, 32'd0);
        rst_ni = 1'b1;
        mdl_fetch = BOOT;
        mdl_pend = 1'b0;
        exp_pc = BOOT;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        prev_br = 1'b0;
    endtask

    task automatic step(input logic br, input logic [31:0] tgt);
        int unsigned due;
        @(negedge clk);
        branch_i = br;
        branch_target_i = tgt;
        id_ready_i = ($urandom_range(99) < ready_pct);
        instr_gnt_i = ($urandom_range(99) < gnt_pct);
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i = $urandom();
        end
        #1;
        s_req = instr_req_o;
        s_valid = instr_valid_o;
        s_addr = instr_addr_o;
        s_pc = instr_pc_o;

        if (prev_req && !prev_gnt) chk("req_held", instr_req_o, 32'd1);
        if (instr_req_o) chk("req_addr", instr_addr_o, mdl_fetch);
        if (instr_req_o && instr_gnt_i) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(instr_addr_o);
            mq_due.push_back(due);
            glog.push_back(instr_addr_o);
            grants++;
            chk("outstanding_bound", 32'(mq_addr.size() <= D), 32'd1);
            mdl_fetch = mdl_pend ? mdl_pend_tgt : mdl_fetch + 32'd4;
            mdl_pend = 1'b0;
        end

        if (prev_br) chk("valid_after_redirect", instr_valid_o, 32'd0);
        if (instr_valid_o && id_ready_i && !br) begin
            chk("out_pc", instr_pc_o, exp_pc);
            chk("out_instr", instr_rdata_o, mem_word(exp_pc));
            if (capture_first) begin
                first_acc_pc = instr_pc_o;
                capture_first = 1'b0;
            end
            exp_pc = exp_pc + 32'd4;
            accepts++;
        end

        if (br) begin
            exp_pc = {tgt[31:2], 2'b00};
            if (instr_req_o && !instr_gnt_i) begin
                mdl_pend = 1'b1;
                mdl_pend_tgt = {tgt[31:2], 2'b00};
            end else begin
                mdl_fetch = {tgt[31:2], 2'b00};
                mdl_pend = 1'b0;
            end
        end
        prev_req = instr_req_o;
        prev_gnt = instr_gnt_i;
        prev_br = br;
        cyc++;
    endtask

    initial begin
        // Boot with zero-wait memory
        gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        step(1'b0, '0);
        chk("boot_req", s_req, 32'd1);
        chk("boot_addr0", s_addr, 32'h80);
        step(1'b0, '0);
        chk("boot_addr1", s_addr, 32'h84);
        step(1'b0, '0);
        chk("boot_addr2", s_addr, 32'h88);
        chk("first_valid", s_valid, 32'd1);
        chk("first_pc", s_pc, 32'h80);
        base = accepts;
        repeat (20) step(1'b0, '0);
        chk("throughput", 32'(accepts - base), 32'd20);

        // Backpressure
        ready_pct = 0;
        do_reset();
        base = grants;
        repeat (10) step(1'b0, '0);
        chk("bp_grants", 32'(grants - base), 32'd2);
        chk("bp_req_low", s_req, 32'd0);
        chk("bp_valid", s_valid, 32'd1);
        chk("bp_pc_hold", s_pc, 32'h80);
        ready_pct = 100;
        base = accepts;
        repeat (20) step(1'b0, '0);
        chk("bp_resume", 32'(accepts - base), 32'd20);

        // Grant stall
        do_reset();
        gnt_pct = 100;
        step(1'b0, '0);
        gnt_pct = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0);
            chk("stall_req", s_req, 32'd1);
            chk("stall_addr", s_addr, 32'h84);
        end
        gnt_pct = 100;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("stall_advance", s_addr, 32'h88);

        // Redirect with two transactions outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        capture_first = 1'b1;
        first_acc_pc = 'x;
        step(1'b1, 32'h203);
        repeat (12) step(1'b0, '0);
        chk("redir_first_pc", first_acc_pc, 32'h200);

        // Redirect while a request waits for its grant
        lat_min = 1; lat_max = 1;
        do_reset();
        step(1'b0, '0);
        step(1'b0, '0);
        gnt_pct = 0;
        capture_first = 1'b1;
        first_acc_pc = 'x;
        step(1'b1, 32'h400);
        chk("pend_req", s_req, 32'd1);
        chk("pend_addr", s_addr, 32'h88);
        step(1'b0, '0);
        chk("pend_frozen", s_addr, 32'h88);
        gnt_pct = 100;
        step(1'b0, '0);
        step(1'b0, '0);
        chk("pend_next_req", s_req, 32'd1);
        chk("pend_next_addr", s_addr, 32'h400);
        repeat (6) step(1'b0, '0);
        chk("pend_first_pc", first_acc_pc, 32'h400);

        // Address wrap
        step(1'b1, 32'hFFFF_FFF8);
        glog.delete();
        repeat (6) step(1'b0, '0);
        chk("wrap_count", 32'(glog.size() >= 3), 32'd1);
        chk("wrap_a0", (glog.size() > 0) ? glog[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        chk("wrap_a1", (glog.size() > 1) ? glog[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        chk("wrap_a2", (glog.size() > 2) ? glog[2] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Randomized traffic
        gnt_pct = 60; ready_pct = 70; lat_min = 1; lat_max = 4;
        do_reset();
        base = accepts;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 3, $urandom());
        end
        chk("random_progress", 32'(accepts - base > 200), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
